experiment_emulator: RTL and testbench
======================================

Name: experiment_emulator

Overview:
- Closed-loop stand-in for the physical experiment rig, used for bench and bring-up testing of the experiment-sequencing FSM.
- Generates the rig-side signals the FSM consumes: start_signal, fg_signal, wire_signal and detector_ready.
- Responds to the FSM's detonation_signal and output_trigger with programmable delays and pulse widths.
- Measures the FSM's response latencies and reports timeouts, so a sequence can run end-to-end with no hardware.

Parameters:
- CNT_W, 32: width of all delay counters and measurement registers.
- FG_DELAY, 100: cycles from start_signal rise to fg_signal rise; legal range 1..2^CNT_W-1.
- FG_PULSE_LEN, 10: fg_signal high time in cycles, >=1.
- WIRE_DELAY, 50: cycles from detected detonation rise to wire_signal rise, >=1.
- WIRE_PULSE_LEN, 10: wire_signal high time in cycles, >=1.
- BUSY_LEN, 500: detector_ready low time after trigger detect, >=1.
- TIMEOUT, 1_000_000: maximum wait for detonation or trigger before error.

Ports:
- clock, in, 1: system clock.
- reset_signal, in, 1: asynchronous, active-low reset.
- go, in, 1: synchronous level; a rising edge starts one run.
- detonation_signal, in, 1: from the FSM.
- output_trigger, in, 1: from the FSM.
- start_signal, out, 1: to the FSM.
- fg_signal, out, 1: to the FSM.
- wire_signal, out, 1: to the FSM.
- detector_ready, out, 1: to the FSM.
- done, out, 1: run completed without error.
- error, out, 1: a timeout occurred.
- error_code, out, 2: 0 none, 1 detonation timeout, 2 trigger timeout.
- fg_to_det, out, CNT_W: measured cycles from fg_signal rise to detonation detect.
- trig_width, out, CNT_W: measured output_trigger high cycles.
- emu_state, out, 8: current state, zero-extended.

Behaviour:
- Reset values (while reset_signal=0): all outputs 0 except detector_ready=1; state=IDLE; counters 0; edge registers 0.
- Edge detection: one register per input; rise = (prev==0 && cur==1). Inputs are synchronous to clock, so no synchronizer.
- IDLE:
  - detector_ready=1; start_signal, fg_signal, wire_signal=0.
  - go rise -> clear done, error, error_code, fg_to_det, trig_width; start_signal=1 from the next cycle; counter=0; go to FG_WAIT.
- FG_WAIT: counter increments each cycle; when counter==FG_DELAY-1, fg_signal=1, counter=0 -> FG_PULSE. Net result: fg_signal rises exactly FG_DELAY cycles after start_signal.
- FG_PULSE: fg_signal is held for FG_PULSE_LEN cycles, then cleared; counter=0 -> WAIT_DET.
- WAIT_DET:
  - fg_to_det counts every cycle from fg_signal rise, including FG_PULSE, and saturates at all-ones.
  - detonation rise -> freeze fg_to_det; counter=0 -> WIRE_WAIT.
  - Counter reaches TIMEOUT first -> error=1, error_code=1, start_signal=0 -> FAULT.
  - A detonation rise during FG_PULSE is counted and is then accepted in WAIT_DET only if detonation_signal is still high, via a level check.
- WIRE_WAIT: wire_signal rises WIRE_DELAY cycles after the detect cycle; counter=0 -> WIRE_PULSE.
- WIRE_PULSE: wire_signal is high for WIRE_PULSE_LEN cycles, then cleared -> WAIT_TRIG.
  - An output_trigger rise during WIRE_WAIT or WIRE_PULSE is latched as pending.
  - A pending rise is accepted immediately on entry to WAIT_TRIG.
- WAIT_TRIG:
  - Trigger rise or pending -> detector_ready=0; counter=0 -> BUSY.
  - Counter reaches TIMEOUT -> error_code=2 -> FAULT.
- BUSY:
  - detector_ready stays low for BUSY_LEN cycles, then returns to 1.
  - trig_width counts cycles where output_trigger==1 from the detect cycle onward, saturating; measurement continues until the trigger falls.
  - Exit -> DONE once the BUSY_LEN count has completed and output_trigger==0.
- DONE: done=1; start_signal=0; go==0 -> IDLE (done stays set until the next go rise).
- FAULT: all pulse outputs 0; detector_ready=1; error held; go==0 -> IDLE.
- go rise outside IDLE is ignored.
- Asynchronous reset mid-run aborts immediately to the reset values; no partial pulses follow.
- Undefined state encoding -> IDLE.

Optional Feature:
- Macro: EMU_JITTER_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances once per cycle.
  - On entry to WIRE_WAIT, its low 4 bits are captured and added to WIRE_DELAY, giving a 0..15 cycle extension.
  - The captured value is visible on emu_state[7:4].
- When undefined: wire delay is exactly WIRE_DELAY; emu_state[7:4]=0; no LFSR logic is synthesized.

Test Plan:
- Nominal run: FG_DELAY=100, FG_PULSE_LEN=10, WIRE_DELAY=50, BUSY_LEN=500. go rise; FSM model detonates 400 cycles after fg rise and triggers 200 cycles wide.
  - Required: fg_signal rises 100 cycles after start_signal.
  - Required: wire_signal rises 50 cycles after detonation, 10 wide.
  - Required: detector_ready low exactly 500 cycles; fg_to_det=400; trig_width=200; done=1; error=0.
- Detonation never arrives, TIMEOUT=1000 -> error=1, error_code=1, start_signal falls 1000 cycles after entering WAIT_DET; go low -> IDLE.
- Trigger never arrives -> error_code=2 after TIMEOUT cycles in WAIT_TRIG; detector_ready remains 1.
- Trigger rising during WIRE_PULSE -> latched; detector_ready falls on the first WAIT_TRIG cycle; run completes with done=1.
- reset_signal low for 1 cycle during BUSY -> detector_ready=1 and all other outputs 0 immediately; go held high afterward does not restart a run until go falls and rises again.
- EMU_JITTER_EN defined: 16 runs from reset -> each wire delay lies in 50..65 and the sequence of delays is identical across two resets.

Source files
------------

// File: rtl/experiment_emulator.sv
// experiment_emulator: closed-loop rig stand-in driving start/fg/wire/detector_ready and timing the FSM's replies.
// Optional macro EMU_JITTER_EN adds a 0..15 cycle LFSR-derived extension to the wire delay.
module experiment_emulator #(
  parameter int          CNT_W          = 32,
  parameter int unsigned FG_DELAY       = 100,
  parameter int unsigned FG_PULSE_LEN   = 10,
  parameter int unsigned WIRE_DELAY     = 50,
  parameter int unsigned WIRE_PULSE_LEN = 10,
  parameter int unsigned BUSY_LEN       = 500,
  parameter int unsigned TIMEOUT        = 1_000_000
) (
  input  logic             clock,
  input  logic             reset_signal,
  input  logic             go,
  input  logic             detonation_signal,
  input  logic             output_trigger,
  output logic             start_signal,
  output logic             fg_signal,
  output logic             wire_signal,
  output logic             detector_ready,
  output logic             done,
  output logic             error,
  output logic [1:0]       error_code,
  output logic [CNT_W-1:0] fg_to_det,
  output logic [CNT_W-1:0] trig_width,
  output logic [7:0]       emu_state
);
  typedef enum logic [3:0] {
    IDLE, FG_WAIT, FG_PULSE, WAIT_DET, WIRE_WAIT, WIRE_PULSE, WAIT_TRIG, BUSY, DONE, FAULT
  } state_t;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] FG_LAST   = CNT_W'(FG_DELAY - 1);
  localparam logic [CNT_W-1:0] FGP_LAST  = CNT_W'(FG_PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] WP_LAST   = CNT_W'(WIRE_PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_LEN - 1);
  localparam logic [CNT_W-1:0] BUSY_END  = CNT_W'(BUSY_LEN);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             go_q, det_q, trig_q, go_armed;
  logic             det_early, trig_pend, meas;
  logic             go_rise, det_rise, trig_rise, det_accept;
  logic [3:0]       jit, jit_next;
  logic [CNT_W-1:0] wd, wd_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  // go_armed blocks a level that was already high when reset released from looking like a rise
  assign go_rise    = go & ~go_q & go_armed;
  assign det_rise   = detonation_signal & ~det_q;
  assign trig_rise  = output_trigger & ~trig_q;
  assign det_accept = det_rise | (det_early & detonation_signal);
  // the detect edge is one cycle after detonation rose, so the wait state covers WIRE_DELAY-1 edges
  assign wd         = CNT_W'(WIRE_DELAY) + CNT_W'(jit);
  assign wd_now     = CNT_W'(WIRE_DELAY) + CNT_W'(jit_next);
  assign emu_state  = {jit, state};

`ifdef EMU_JITTER_EN
  logic [15:0] lfsr;
  // free-running Fibonacci LFSR; its low nibble is latched as the wire-delay extension at detonation accept
  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      lfsr <= 16'hACE1;
      jit  <= 4'd0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (state == WAIT_DET && det_accept) jit <= lfsr[3:0];
    end
  end
  assign jit_next = lfsr[3:0];
`else
  assign jit      = 4'd0;
  assign jit_next = 4'd0;
`endif

  // run sequencer: edge registers, pulse generation, latency measurement and timeouts
  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      state          <= IDLE;
      cnt            <= '0;
      go_q           <= 1'b0;
      det_q          <= 1'b0;
      trig_q         <= 1'b0;
      go_armed       <= 1'b0;
      det_early      <= 1'b0;
      trig_pend      <= 1'b0;
      meas           <= 1'b0;
      start_signal   <= 1'b0;
      fg_signal      <= 1'b0;
      wire_signal    <= 1'b0;
      detector_ready <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
      error_code     <= 2'd0;
      fg_to_det      <= '0;
      trig_width     <= '0;
    end else begin
      go_q   <= go;
      det_q  <= detonation_signal;
      trig_q <= output_trigger;
      if (!go) go_armed <= 1'b1;
      case (state)
        IDLE: begin
          detector_ready <= 1'b1;
          start_signal   <= 1'b0;
          fg_signal      <= 1'b0;
          wire_signal    <= 1'b0;
          if (go_rise) begin
            done         <= 1'b0;
            error        <= 1'b0;
            error_code   <= 2'd0;
            fg_to_det    <= '0;
            trig_width   <= '0;
            det_early    <= 1'b0;
            trig_pend    <= 1'b0;
            meas         <= 1'b0;
            start_signal <= 1'b1;
            cnt          <= '0;
            state        <= FG_WAIT;
          end
        end
        FG_WAIT: begin
          if (cnt == FG_LAST) begin
            fg_signal <= 1'b1;
            cnt       <= '0;
            state     <= FG_PULSE;
          end else cnt <= cnt + ONE;
        end
        FG_PULSE: begin
          fg_to_det <= sat_inc(fg_to_det);
          if (det_rise) det_early <= 1'b1;
          if (cnt == FGP_LAST) begin
            fg_signal <= 1'b0;
            cnt       <= '0;
            state     <= WAIT_DET;
          end else cnt <= cnt + ONE;
        end
        WAIT_DET: begin
          if (det_accept) begin
            wire_signal <= (wd_now == ONE);
            cnt         <= (wd_now == ONE) ? '0 : ONE;
            state       <= (wd_now == ONE) ? WIRE_PULSE : WIRE_WAIT;
          end else begin
            fg_to_det <= sat_inc(fg_to_det);
            if (cnt == TO_LAST) begin
              error        <= 1'b1;
              error_code   <= 2'd1;
              start_signal <= 1'b0;
              state        <= FAULT;
            end else cnt <= cnt + ONE;
          end
        end
        WIRE_WAIT: begin
          if (trig_rise) trig_pend <= 1'b1;
          if (cnt == wd - ONE) begin
            wire_signal <= 1'b1;
            cnt         <= '0;
            state       <= WIRE_PULSE;
          end else cnt <= cnt + ONE;
        end
        WIRE_PULSE: begin
          if (trig_rise) trig_pend <= 1'b1;
          if (cnt == WP_LAST) begin
            wire_signal <= 1'b0;
            cnt         <= '0;
            state       <= WAIT_TRIG;
          end else cnt <= cnt + ONE;
        end
        WAIT_TRIG: begin
          if (trig_rise || trig_pend) begin
            detector_ready <= 1'b0;
            trig_width     <= output_trigger ? ONE : '0;
            meas           <= output_trigger;
            trig_pend      <= 1'b0;
            cnt            <= '0;
            state          <= BUSY;
          end else if (cnt == TO_LAST) begin
            error        <= 1'b1;
            error_code   <= 2'd2;
            start_signal <= 1'b0;
            state        <= FAULT;
          end else cnt <= cnt + ONE;
        end
        BUSY: begin
          if (meas && output_trigger) trig_width <= sat_inc(trig_width);
          if (!output_trigger) meas <= 1'b0;
          if (cnt != BUSY_END) cnt <= cnt + ONE;
          if (cnt >= BUSY_LAST) detector_ready <= 1'b1;
          if (cnt >= BUSY_LAST && !output_trigger) begin
            done         <= 1'b1;
            start_signal <= 1'b0;
            state        <= DONE;
          end
        end
        DONE: begin
          start_signal <= 1'b0;
          if (!go) state <= IDLE;
        end
        FAULT: begin
          start_signal   <= 1'b0;
          fg_signal      <= 1'b0;
          wire_signal    <= 1'b0;
          detector_ready <= 1'b1;
          if (!go) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_experiment_emulator.sv
// tb_experiment_emulator: directed self-checking bench for experiment_emulator (jitter runs when EMU_JITTER_EN is defined).
module tb_experiment_emulator;
  localparam int CNT_W  = 32;
  localparam int S_FG   = 0;
  localparam int S_WIRE = 1;
  localparam int S_ST   = 2;
  localparam int S_RDY  = 3;
  localparam int S_DONE = 4;

  logic             clock = 1'b0;
  logic             reset_signal = 1'b0;
  logic             go = 1'b0;
  logic             detonation_signal = 1'b0;
  logic             output_trigger = 1'b0;
  logic             start_signal, fg_signal, wire_signal, detector_ready, done, error;
  logic [1:0]       error_code;
  logic [CNT_W-1:0] fg_to_det, trig_width;
  logic [7:0]       emu_state;
  int               checks = 0;
  int               errors = 0;

  experiment_emulator #(
    .CNT_W(CNT_W), .FG_DELAY(100), .FG_PULSE_LEN(10), .WIRE_DELAY(50),
    .WIRE_PULSE_LEN(10), .BUSY_LEN(500), .TIMEOUT(1000)
  ) dut (
    .clock(clock), .reset_signal(reset_signal), .go(go),
    .detonation_signal(detonation_signal), .output_trigger(output_trigger),
    .start_signal(start_signal), .fg_signal(fg_signal), .wire_signal(wire_signal),
    .detector_ready(detector_ready), .done(done), .error(error), .error_code(error_code),
    .fg_to_det(fg_to_det), .trig_width(trig_width), .emu_state(emu_state)
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      S_FG:    return fg_signal;
      S_WIRE:  return wire_signal;
      S_ST:    return start_signal;
      S_RDY:   return detector_ready;
      S_DONE:  return done;
      default: return 1'bx;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int sel, input logic val, input int limit, output int n);
    n = 0;
    while (sig(sel) !== val && n < limit) begin
      tick();
      n++;
    end
    chk(tag, 64'(sig(sel)), 64'(val));
  endtask

`ifdef EMU_JITTER_EN
  task automatic run_jit(output int d);
    int n;
    go = 1'b1;
    tick();
    wait_sig("j_fg_rise", S_FG, 1'b1, 200, n);
    wait_sig("j_fg_fall", S_FG, 1'b0, 20, n);
    detonation_signal = 1'b1;
    wait_sig("j_wire_rise", S_WIRE, 1'b1, 100, d);
    wait_sig("j_wire_fall", S_WIRE, 1'b0, 20, n);
    output_trigger = 1'b1;
    tick();
    output_trigger = 1'b0;
    detonation_signal = 1'b0;
    wait_sig("j_done", S_DONE, 1'b1, 600, n);
    go = 1'b0;
    tick();
  endtask
`endif

  initial begin
    int n, m;
`ifdef EMU_JITTER_EN
    int d1 [16];
    int d2 [16];
`endif
    tick();
    tick();
    chk("rst_ready", 64'(detector_ready), 1);
    chk("rst_start", 64'(start_signal), 0);
    chk("rst_fg", 64'(fg_signal), 0);
    chk("rst_wire", 64'(wire_signal), 0);
    chk("rst_done_err", 64'({done, error, error_code}), 0);
    chk("rst_meas", 64'({fg_to_det, trig_width}), 0);
    chk("rst_state", 64'(emu_state), 0);
    reset_signal = 1'b1;
    tick();

    // nominal run
    go = 1'b1;
    tick();
    chk("nom_start", 64'(start_signal), 1);
    wait_sig("nom_fg_rise", S_FG, 1'b1, 200, n);
    chk("nom_fg_delay", 64'(n), 100);
    wait_sig("nom_fg_fall", S_FG, 1'b0, 50, n);
    chk("nom_fg_width", 64'(n), 10);
    for (int i = 0; i < 390; i++) tick();
    detonation_signal = 1'b1;
    wait_sig("nom_wire_rise", S_WIRE, 1'b1, 100, n);
`ifdef EMU_JITTER_EN
    chk("nom_wire_delay_range", 64'(n >= 50 && n <= 65), 1);
`else
    chk("nom_wire_delay", 64'(n), 50);
`endif
    chk("nom_fg_to_det", 64'(fg_to_det), 400);
    wait_sig("nom_wire_fall", S_WIRE, 1'b0, 50, n);
    chk("nom_wire_width", 64'(n), 10);
    detonation_signal = 1'b0;
    output_trigger = 1'b1;
    wait_sig("nom_ready_fall", S_RDY, 1'b0, 5, n);
    chk("nom_ready_fall_lat", 64'(n), 1);
    for (int i = 0; i < 199; i++) tick();
    output_trigger = 1'b0;
    wait_sig("nom_ready_rise", S_RDY, 1'b1, 600, m);
    chk("nom_busy_low", 64'(199 + m), 500);
    chk("nom_done", 64'(done), 1);
    chk("nom_error", 64'({error, error_code}), 0);
    chk("nom_trig_width", 64'(trig_width), 200);
    chk("nom_start_low", 64'(start_signal), 0);
    go = 1'b0;
    tick();
    chk("nom_idle", 64'(emu_state[3:0]), 0);
    chk("nom_done_held", 64'(done), 1);

    // detonation timeout
    go = 1'b1;
    tick();
    chk("dto_done_cleared", 64'(done), 0);
    wait_sig("dto_fg_rise", S_FG, 1'b1, 200, n);
    wait_sig("dto_fg_fall", S_FG, 1'b0, 50, n);
    wait_sig("dto_start_fall", S_ST, 1'b0, 1100, n);
    chk("dto_latency", 64'(n), 1000);
    chk("dto_error", 64'(error), 1);
    chk("dto_code", 64'(error_code), 1);
    chk("dto_ready", 64'(detector_ready), 1);
    go = 1'b0;
    tick();
    chk("dto_idle", 64'(emu_state[3:0]), 0);

    // trigger timeout, detonation right at WAIT_DET entry
    go = 1'b1;
    tick();
    chk("tto_error_cleared", 64'({error, error_code}), 0);
    wait_sig("tto_fg_rise", S_FG, 1'b1, 200, n);
    wait_sig("tto_fg_fall", S_FG, 1'b0, 50, n);
    detonation_signal = 1'b1;
    wait_sig("tto_wire_rise", S_WIRE, 1'b1, 100, n);
    chk("tto_fg_to_det", 64'(fg_to_det), 10);
    wait_sig("tto_wire_fall", S_WIRE, 1'b0, 50, n);
    wait_sig("tto_start_fall", S_ST, 1'b0, 1100, n);
    chk("tto_latency", 64'(n), 1000);
    chk("tto_code", 64'({error, error_code}), 64'h6);
    chk("tto_ready", 64'(detector_ready), 1);
    detonation_signal = 1'b0;
    go = 1'b0;
    tick();

    // trigger rising during WIRE_PULSE is latched
    go = 1'b1;
    tick();
    wait_sig("pend_fg_rise", S_FG, 1'b1, 200, n);
    wait_sig("pend_fg_fall", S_FG, 1'b0, 50, n);
    detonation_signal = 1'b1;
    wait_sig("pend_wire_rise", S_WIRE, 1'b1, 100, n);
    tick();
    tick();
    tick();
    output_trigger = 1'b1;
    wait_sig("pend_wire_fall", S_WIRE, 1'b0, 50, n);
    chk("pend_ready_before", 64'(detector_ready), 1);
    tick();
    chk("pend_ready_first_wait_trig", 64'(detector_ready), 0);
    chk("pend_width_start", 64'(trig_width), 1);
    for (int i = 0; i < 19; i++) tick();
    output_trigger = 1'b0;
    detonation_signal = 1'b0;
    wait_sig("pend_done", S_DONE, 1'b1, 600, n);
    chk("pend_busy_rest", 64'(19 + n), 500);
    chk("pend_trig_width", 64'(trig_width), 20);
    chk("pend_error", 64'(error), 0);
    go = 1'b0;
    tick();

    // asynchronous reset during BUSY, then go held high
    go = 1'b1;
    tick();
    wait_sig("rb_fg_rise", S_FG, 1'b1, 200, n);
    wait_sig("rb_fg_fall", S_FG, 1'b0, 50, n);
    detonation_signal = 1'b1;
    wait_sig("rb_wire_rise", S_WIRE, 1'b1, 100, n);
    wait_sig("rb_wire_fall", S_WIRE, 1'b0, 50, n);
    output_trigger = 1'b1;
    wait_sig("rb_ready_fall", S_RDY, 1'b0, 5, n);
    for (int i = 0; i < 5; i++) tick();
    reset_signal = 1'b0;
    detonation_signal = 1'b0;
    output_trigger = 1'b0;
    #1;
    chk("rb_ready", 64'(detector_ready), 1);
    chk("rb_pulses", 64'({start_signal, fg_signal, wire_signal}), 0);
    chk("rb_status", 64'({done, error, error_code}), 0);
    chk("rb_meas", 64'({fg_to_det, trig_width}), 0);
    chk("rb_state", 64'(emu_state), 0);
    #1;
    reset_signal = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("rb_no_restart_start", 64'(start_signal), 0);
    chk("rb_no_restart_state", 64'(emu_state[3:0]), 0);
    go = 1'b0;
    tick();
    go = 1'b1;
    tick();
    chk("rb_restart", 64'(start_signal), 1);
    go = 1'b0;

`ifdef EMU_JITTER_EN
    reset_signal = 1'b0;
    tick();
    reset_signal = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      run_jit(d1[i]);
      chk("jit_range", 64'(d1[i] >= 50 && d1[i] <= 65), 1);
    end
    reset_signal = 1'b0;
    tick();
    reset_signal = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      run_jit(d2[i]);
      chk("jit_repeat", 64'(d2[i]), 64'(d1[i]));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
